// File: rtl/bcd_pkg.sv
// Shared constants and types for the packed-BCD adder datapath.
// Digit width, largest legal digit value and the decimal correction term.
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // True when a 4-bit code is not a legal decimal digit (10..15).
    function automatic logic is_bad_digit(input bcd_digit_t d);
        return d > bcd_digit_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_adder_digit_add.sv
// Combinational single-digit decimal adder with +6 correction.
// Non-BCD digits follow the same rule and are flagged through bad_digit.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout,
    output logic       bad_digit
);

    logic [BCD_W:0] z;

    // Worst case 15+15+1 = 31 fits in five bits; the correction wraps mod 16.
    always_comb begin
        z         = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        digit     = z[BCD_W-1:0];
        cout      = 1'b0;
        bad_digit = is_bad_digit(a) | is_bad_digit(b);
        if (z > (BCD_W+1)'(BCD_MAX)) begin
            digit = z[BCD_W-1:0] + bcd_digit_t'(BCD_CORR);
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_adder.sv
// Registered N-digit packed-BCD adder: ripple of digit adders, one output register stage.
// Results and flags hold their last value while no new operation is accepted.
module bcd_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    carry_in,
    output logic                    out_valid,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    carry,
    output logic                    invalid
);

    logic [DIGITS:0]             chain;
    logic [BCD_W*DIGITS-1:0]     digit_sum;
    logic [DIGITS-1:0]           bad;

    assign chain[0] = carry_in;

    // Digit 0 sits in the low nibble; carries ripple toward the high digits.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_add u_digit (
            .a         (a[i*BCD_W +: BCD_W]),
            .b         (b[i*BCD_W +: BCD_W]),
            .cin       (chain[i]),
            .digit     (digit_sum[i*BCD_W +: BCD_W]),
            .cout      (chain[i+1]),
            .bad_digit (bad[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum     <= digit_sum;
                carry   <= chain[DIGITS];
                invalid <= |bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_adder.sv
// Directed self-checking bench: one 1-digit and one 4-digit adder share clock and reset.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_bcd_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  a1, b1;
    logic        cin1;
    logic [15:0] a4, b4;
    logic        cin4;

    logic        out_valid1, carry1, invalid1;
    logic [3:0]  sum1;
    logic        out_valid4, carry4, invalid4;
    logic [15:0] sum4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_adder #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .carry_in  (cin1),
        .out_valid (out_valid1),
        .sum       (sum1),
        .carry     (carry1),
        .invalid   (invalid1)
    );

    bcd_adder #(.DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .carry_in  (cin4),
        .out_valid (out_valid4),
        .sum       (sum4),
        .carry     (carry4),
        .invalid   (invalid4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one operation into both adders and step past the capturing edge.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                                 input logic [15:0] aw, input logic [15:0] bw, input logic cw);
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv;
        a4 = aw; b4 = bw; cin4 = cw;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic [3:0] s, input logic c, input logic inv);
        checkOutput({tag, ".valid"},   32'(out_valid1), 32'd1);
        checkOutput({tag, ".sum"},     32'(sum1),       32'(s));
        checkOutput({tag, ".carry"},   32'(carry1),     32'(c));
        checkOutput({tag, ".invalid"}, 32'(invalid1),   32'(inv));
    endtask

    task automatic check4(input string tag, input logic [15:0] s, input logic c, input logic inv);
        checkOutput({tag, ".valid4"},   32'(out_valid4), 32'd1);
        checkOutput({tag, ".sum4"},     32'(sum4),       32'(s));
        checkOutput({tag, ".carry4"},   32'(carry4),     32'(c));
        checkOutput({tag, ".invalid4"}, 32'(invalid4),   32'(inv));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1;
        a1 = 4'h9; b1 = 4'h9; cin1 = 1'b0;
        a4 = 16'h9999; b4 = 16'h9999; cin4 = 1'b0;

        // Reset held for two edges while valid operands are presented.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst.valid",    32'(out_valid1), 32'd0);
            checkOutput("rst.sum",      32'(sum1),       32'd0);
            checkOutput("rst.carry",    32'(carry1),     32'd0);
            checkOutput("rst.invalid",  32'(invalid1),   32'd0);
            checkOutput("rst.valid4",   32'(out_valid4), 32'd0);
            checkOutput("rst.sum4",     32'(sum4),       32'd0);
        end

        // First result after reset release: 9+9 = 18 -> digit 8, carry 1.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check1("post_rst", 4'h8, 1'b1, 1'b0);
        check4("post_rst", 16'h9998, 1'b1, 1'b0);

        applyStimulus(4'h3, 4'h4, 1'b0, 16'h1234, 16'h5678, 1'b0);
        check1("basic", 4'h7, 1'b0, 1'b0);
        check4("ripple_mix", 16'h6912, 1'b0, 1'b0);

        applyStimulus(4'h7, 4'h7, 1'b1, 16'h9999, 16'h0000, 1'b1);
        check1("corr_7_7_1", 4'h5, 1'b1, 1'b0);
        check4("ripple_all", 16'h0000, 1'b1, 1'b0);

        applyStimulus(4'h9, 4'h7, 1'b1, 16'h0000, 16'h0000, 1'b0);
        check1("corr_9_7_1", 4'h7, 1'b1, 1'b0);
        check4("zero", 16'h0000, 1'b0, 1'b0);

        applyStimulus(4'h9, 4'h0, 1'b0, 16'h12a4, 16'h0001, 1'b0);
        check1("edge_9", 4'h9, 1'b0, 1'b0);
        check4("bad_digit4", 16'h1305, 1'b0, 1'b1);

        applyStimulus(4'he, 4'h3, 1'b0, 16'h4999, 16'h5000, 1'b1);
        check1("nonbcd_14_3", 4'h7, 1'b0 | 1'b1, 1'b1);
        check4("ripple_top", 16'h0000, 1'b1, 1'b0);

        applyStimulus(4'hd, 4'h7, 1'b1, 16'h0009, 16'h0009, 1'b0);
        check1("nonbcd_13_7", 4'hb, 1'b1, 1'b1);
        check4("low_carry", 16'h0018, 1'b0, 1'b0);

        applyStimulus(4'hf, 4'h6, 1'b1, 16'h0500, 16'h0f00, 1'b0);
        check1("nonbcd_15_6", 4'hc, 1'b1, 1'b1);
        check4("bad_b4", 16'h1a00, 1'b0, 1'b1);

        // Idle cycle: valid drops, last result must be held.
        @(negedge clk);
        in_valid = 1'b0;
        a1 = 4'h1; b1 = 4'h1; cin1 = 1'b0;
        a4 = 16'h1111; b4 = 16'h1111; cin4 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold.valid",   32'(out_valid1), 32'd0);
        checkOutput("hold.sum",     32'(sum1),       32'hc);
        checkOutput("hold.carry",   32'(carry1),     32'd1);
        checkOutput("hold.invalid", 32'(invalid1),   32'd1);
        checkOutput("hold.valid4",  32'(out_valid4), 32'd0);
        checkOutput("hold.sum4",    32'(sum4),       32'h1a00);

        // Reset mid-stream discards the operation presented with it.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst2.valid", 32'(out_valid1), 32'd0);
        checkOutput("rst2.sum",   32'(sum1),       32'd0);
        checkOutput("rst2.carry", 32'(carry1),     32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst2.idle_valid", 32'(out_valid1), 32'd0);
        checkOutput("rst2.idle_sum",   32'(sum1),       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
